// File: rtl/object_kinematics.sv
// Ballistic motion for one on-screen object: gravity, terminal
// velocity, side-wall bounce or exit, and launch/kill control.
module object_kinematics #(
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int VW       = 8,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int GRAVITY  = 1,
  parameter int VY_MAX   = 15,
  parameter int BOUNCE_X = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          moveclk,
  input  logic          launch,
  input  logic          kill,
  input  logic          pause,
  input  logic [XW-1:0] init_x,
  input  logic [YW-1:0] init_y,
  input  logic [VW-1:0] init_vx,
  input  logic [VW-1:0] init_vy,
  output logic [XW-1:0] posx,
  output logic [YW-1:0] posy,
  output logic [VW-1:0] vx,
  output logic [VW-1:0] vy,
  output logic          active,
  output logic          done,
  output logic [1:0]    exit_code
);

  localparam int W = ((XW > YW) ? XW : YW) + 2;

  localparam logic signed [W-1:0] C_XMAX  = W'(X_MAX);
  localparam logic signed [W-1:0] C_YMAX  = W'(Y_MAX);
  localparam logic signed [W-1:0] C_VYMAX = W'(VY_MAX);
  localparam logic signed [W-1:0] C_GRAV  = W'(GRAVITY);
  localparam logic [VW-1:0] C_VMIN = {1'b1, {(VW-1){1'b0}}};
  localparam logic [VW-1:0] C_VPOS = {1'b0, {(VW-1){1'b1}}};

  typedef enum logic {S_IDLE, S_FLY} state_t;

  state_t        r_state, w_state_nxt;
  logic [XW-1:0] r_posx, w_posx_nxt;
  logic [YW-1:0] r_posy, w_posy_nxt;
  logic [VW-1:0] r_vx, w_vx_nxt;
  logic [VW-1:0] r_vy, w_vy_nxt;
  logic          r_done, w_done_nxt;
  logic [1:0]    r_code, w_code_nxt;

  logic signed [W-1:0] w_nx, w_ny, w_nvy, w_nvy_c;
  logic [VW-1:0]       w_vx_neg;
  logic                w_bot, w_side;

  // Candidate position/velocity for the next physics tick
  always_comb begin
    w_nx = $signed({{(W-XW){1'b0}}, r_posx})
         + $signed({{(W-VW){r_vx[VW-1]}}, r_vx});
    w_ny = $signed({{(W-YW){1'b0}}, r_posy})
         + $signed({{(W-VW){r_vy[VW-1]}}, r_vy});
    w_nvy = $signed({{(W-VW){r_vy[VW-1]}}, r_vy}) + C_GRAV;
    w_nvy_c = (w_nvy > C_VYMAX) ? C_VYMAX : w_nvy;
    w_vx_neg = (r_vx == C_VMIN) ? C_VPOS : (~r_vx + 1'b1);
    w_bot = w_ny > C_YMAX;
    w_side = w_nx[W-1] || (w_nx > C_XMAX);
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt = r_state;
    w_posx_nxt  = r_posx;
    w_posy_nxt  = r_posy;
    w_vx_nxt    = r_vx;
    w_vy_nxt    = r_vy;
    w_done_nxt  = 1'b0;
    w_code_nxt  = r_code;
    unique case (r_state)
      S_IDLE: begin
        if (launch) begin
          w_state_nxt = S_FLY;
          w_posx_nxt  = init_x;
          w_posy_nxt  = init_y;
          w_vx_nxt    = init_vx;
          w_vy_nxt    = init_vy;
          w_code_nxt  = 2'b00;
        end
      end
      S_FLY: begin
        if (kill) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_code_nxt  = 2'b11;
        end else if (!pause && moveclk) begin
          if (w_bot) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_code_nxt  = 2'b01;
          end else if (w_side && (BOUNCE_X == 0)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_code_nxt  = 2'b10;
          end else begin
            if (w_nx[W-1]) begin
              w_posx_nxt = '0;
              w_vx_nxt   = w_vx_neg;
            end else if (w_nx > C_XMAX) begin
              w_posx_nxt = XW'(X_MAX);
              w_vx_nxt   = w_vx_neg;
            end else begin
              w_posx_nxt = w_nx[XW-1:0];
            end
            if (w_ny[W-1]) begin
              w_posy_nxt = '0;
              w_vy_nxt   = '0;
            end else begin
              w_posy_nxt = w_ny[YW-1:0];
              w_vy_nxt   = w_nvy_c[VW-1:0];
            end
          end
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_posx  <= '0;
      r_posy  <= '0;
      r_vx    <= '0;
      r_vy    <= '0;
      r_done  <= 1'b0;
      r_code  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_posx  <= w_posx_nxt;
      r_posy  <= w_posy_nxt;
      r_vx    <= w_vx_nxt;
      r_vy    <= w_vy_nxt;
      r_done  <= w_done_nxt;
      r_code  <= w_code_nxt;
    end
  end

  assign posx      = r_posx;
  assign posy      = r_posy;
  assign vx        = r_vx;
  assign vy        = r_vy;
  assign active    = (r_state == S_FLY);
  assign done      = r_done;
  assign exit_code = r_code;

endmodule
